// File: rtl/gene_pkg.sv
// Shared parameters and types for the banded-alignment stripe scheduler.
package gene_pkg;
  localparam int unsigned PE_NUM      = 64;
  localparam int unsigned SEQ_LEN     = 1024;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned SCORE_W     = 14;
  localparam int unsigned NUM_STRIPES = SEQ_LEN / PE_NUM;
  localparam int unsigned STRIPE_W    = 4;
  localparam int unsigned PE_IDX_W    = $clog2(PE_NUM);
  localparam int unsigned DRAIN_LIMIT = 2 * PE_NUM;
  localparam int unsigned DRAIN_W     = $clog2(DRAIN_LIMIT);
  localparam int unsigned SUM_W       = ADDR_W + 2;

  typedef logic [1:0]          base_t;
  typedef logic [SCORE_W-1:0]  score_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [ADDR_W:0]     row_t;

  typedef struct packed {
    score_t                score;
    row_t                  row;
    logic [STRIPE_W-1:0]   stripe;
  } best_t;

  typedef enum logic [2:0] {IDLE, LOAD_B, GAP, STREAM, DRAIN, UPDATE} sched_state_e;
endpackage

// File: rtl/stripe_b_loader.sv
// Loads PE_NUM gene B bases for one stripe into the parallel B register.
// Addresses go out one per cycle; each base lands one cycle later (sync SRAM).
module stripe_b_loader
  import gene_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_go,
  input  addr_t               i_base,
  output addr_t               o_b_addr,
  input  base_t               i_b_data,
  output logic [2*PE_NUM-1:0] o_pe_b,
  output logic                o_done_c
);

  logic                  issue_q, issue_d;
  logic                  cap_q, cap_d;
  logic [PE_IDX_W-1:0]   cnt_q, cnt_d;
  logic [PE_IDX_W-1:0]   cap_idx_q, cap_idx_d;
  addr_t                 addr_q, addr_d;
  logic [2*PE_NUM-1:0]   b_q, b_d;

  always_comb begin
    issue_d   = issue_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    b_d       = b_q;
    cap_d     = issue_q;
    cap_idx_d = cnt_q;
    if (i_go) begin
      issue_d = 1'b1;
      cnt_d   = '0;
      addr_d  = i_base;
    end else if (issue_q) begin
      if (cnt_q == PE_IDX_W'(PE_NUM - 1)) begin
        issue_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end
    // capture lags the address by one cycle to match SRAM read latency
    if (cap_q) b_d[{cap_idx_q, 1'b0} +: 2] = i_b_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      issue_q   <= 1'b0;
      cap_q     <= 1'b0;
      cnt_q     <= '0;
      cap_idx_q <= '0;
      addr_q    <= '0;
      b_q       <= '0;
    end else begin
      issue_q   <= issue_d;
      cap_q     <= cap_d;
      cnt_q     <= cnt_d;
      cap_idx_q <= cap_idx_d;
      addr_q    <= addr_d;
      b_q       <= b_d;
    end
  end

  assign o_b_addr = addr_q;
  assign o_pe_b   = b_q;
  assign o_done_c = cap_q && (cap_idx_q == PE_IDX_W'(PE_NUM - 1));

endmodule

// File: rtl/stripe_scheduler.sv
// Sequences a full banded alignment as NUM_STRIPES stripes through the PE array,
// carrying the start row between stripes and tracking the global best score.
module stripe_scheduler
  import gene_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_go,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [ADDR_W-1:0]    o_a_addr,
  input  logic [1:0]           i_a_data,
  output logic [ADDR_W-1:0]    o_b_addr,
  input  logic [1:0]           i_b_data,
  output logic                 o_pe_start,
  output logic [1:0]           o_pe_A,
  output logic [2*PE_NUM-1:0]  o_pe_B,
  input  logic                 i_stripe_end,
  input  logic [ADDR_W-1:0]    i_start_pos,
  input  logic [ADDR_W-1:0]    i_end_pos,
  input  logic [SCORE_W-1:0]   i_max_score,
  output logic [SCORE_W-1:0]   o_best_score,
  output logic [ADDR_W:0]      o_best_row,
  output logic [STRIPE_W-1:0]  o_best_stripe
);

  localparam row_t ROW_SEQ_LEN = row_t'(SEQ_LEN);

  sched_state_e          state_q, state_d;
  logic [STRIPE_W-1:0]   k_q, k_d;
  row_t                  start_row_q, start_row_d;
  addr_t                 a_addr_q, a_addr_d;
  logic                  issue_q, issue_d;
  logic                  pe_start_q, pe_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  stripe_to_q, stripe_to_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  best_t                 best_q, best_d;
  logic                  load_go;
  logic                  load_done_c;
  addr_t                 load_base_c;
  logic [SUM_W-1:0]      step_c, sum_c;
  row_t                  cand_row_c;

  stripe_b_loader u_b_loader (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_go     (load_go),
    .i_base   (load_base_c),
    .o_b_addr (o_b_addr),
    .i_b_data (i_b_data),
    .o_pe_b   (o_pe_B),
    .o_done_c (load_done_c)
  );

  // a timed-out stripe does not advance the start row
  assign step_c      = stripe_to_q ? '0 : {2'b00, i_start_pos};
  assign sum_c       = {1'b0, start_row_q} + step_c;
  assign cand_row_c  = {1'b0, i_end_pos} + {1'b0, start_row_q[ADDR_W-1:0]};
  assign load_base_c = ADDR_W'(k_d) << PE_IDX_W;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    start_row_d = start_row_q;
    a_addr_d    = a_addr_q;
    issue_d     = 1'b0;
    pe_start_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    stripe_to_d = stripe_to_q;
    drain_d     = drain_q;
    best_d      = best_q;
    load_go     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_go) begin
          state_d     = LOAD_B;
          load_go     = 1'b1;
          busy_d      = 1'b1;
          k_d         = '0;
          start_row_d = '0;
          timeout_d   = 1'b0;
          stripe_to_d = 1'b0;
          best_d      = '0;
        end
      end
      LOAD_B: begin
        if (load_done_c) state_d = GAP;
      end
      GAP: begin
        if (start_row_q == ROW_SEQ_LEN) begin
          state_d = UPDATE;
        end else begin
          state_d  = STREAM;
          a_addr_d = start_row_q[ADDR_W-1:0];
          issue_d  = 1'b1;
        end
      end
      STREAM: begin
        // early stripe end drops the row whose address is out this cycle
        if (pe_start_q && i_stripe_end) begin
          state_d = UPDATE;
        end else if (issue_q) begin
          pe_start_d = 1'b1;
          if (a_addr_q != ADDR_W'(SEQ_LEN - 1)) begin
            issue_d  = 1'b1;
            a_addr_d = a_addr_q + 1'b1;
          end
        end else begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (i_stripe_end) begin
          state_d = UPDATE;
        end else if (drain_q == DRAIN_W'(DRAIN_LIMIT - 1)) begin
          state_d     = UPDATE;
          timeout_d   = 1'b1;
          stripe_to_d = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      UPDATE: begin
        if (start_row_q != ROW_SEQ_LEN) begin
          start_row_d = (sum_c > SUM_W'(SEQ_LEN)) ? ROW_SEQ_LEN : sum_c[ADDR_W:0];
          if (i_max_score > best_q.score) begin
            best_d.score  = i_max_score;
            best_d.row    = cand_row_c;
            best_d.stripe = k_q;
          end
        end
        stripe_to_d = 1'b0;
        if (k_q == STRIPE_W'(NUM_STRIPES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = LOAD_B;
          k_d     = k_q + 1'b1;
          load_go = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      start_row_q <= '0;
      a_addr_q    <= '0;
      issue_q     <= 1'b0;
      pe_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      stripe_to_q <= 1'b0;
      drain_q     <= '0;
      best_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      start_row_q <= start_row_d;
      a_addr_q    <= a_addr_d;
      issue_q     <= issue_d;
      pe_start_q  <= pe_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      stripe_to_q <= stripe_to_d;
      drain_q     <= drain_d;
      best_q      <= best_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_a_addr      = a_addr_q;
  assign o_pe_start    = pe_start_q;
  assign o_pe_A        = pe_start_q ? i_a_data : 2'b00;
  assign o_best_score  = best_q.score;
  assign o_best_row    = best_q.row;
  assign o_best_stripe = best_q.stripe;

endmodule

// File: tb/tb_stripe_scheduler.sv
// Bench for stripe_scheduler: SRAM models, a behavioural PE array and a
// stripe-level reference model of which rows each stripe streams and the best result.
module tb_stripe_scheduler;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         go = 1'b0;
  logic         busy, done, timeout;
  logic [9:0]   a_addr, b_addr;
  logic [1:0]   a_data, b_data;
  logic         pe_start;
  logic [1:0]   pe_a;
  logic [127:0] pe_b;
  logic         stripe_end = 1'b0;
  logic [9:0]   start_pos = '0;
  logic [9:0]   end_pos;
  logic [13:0]  max_score;
  logic [13:0]  best_score;
  logic [10:0]  best_row;
  logic [3:0]   best_stripe;

  always #5 clk = ~clk;

  stripe_scheduler dut (
    .i_clk(clk), .i_rst(rst_n), .i_go(go),
    .o_busy(busy), .o_done(done), .o_timeout(timeout),
    .o_a_addr(a_addr), .i_a_data(a_data),
    .o_b_addr(b_addr), .i_b_data(b_data),
    .o_pe_start(pe_start), .o_pe_A(pe_a), .o_pe_B(pe_b),
    .i_stripe_end(stripe_end), .i_start_pos(start_pos),
    .i_end_pos(end_pos), .i_max_score(max_score),
    .o_best_score(best_score), .o_best_row(best_row), .o_best_stripe(best_stripe)
  );

  logic [1:0]  a_mem [1024];
  logic [1:0]  b_mem [1024];
  logic [13:0] sc_tab [16];
  logic [9:0]  ep_tab [16];
  logic [9:0]  a_addr_prev;
  int end_mode = 0;
  int run_id = 0;

  // per-stripe outputs of the PE array, selected by the stripe being loaded
  assign end_pos   = ep_tab[b_addr[9:6]];
  assign max_score = sc_tab[b_addr[9:6]];

  always @(posedge clk) begin
    a_data      <= a_mem[a_addr];
    b_data      <= b_mem[b_addr];
    a_addr_prev <= a_addr;
  end

  // observations, written only by the monitor process
  int first_row [16];
  int last_row [16];
  int nrows [16];
  int seq_err, a_err, b_err, done_cnt, load_cnt, cyc, t_last, t_to, drain_cd, seen_id;
  logic [9:0] b_addr_prev;

  always @(negedge clk) begin
    int k, row;
    logic [127:0] bexp;
    cyc++;
    stripe_end = 1'b0;
    if (seen_id != run_id) begin
      seen_id = run_id;
      for (int i = 0; i < 16; i++) begin first_row[i] = -1; last_row[i] = -1; nrows[i] = 0; end
      seq_err = 0; a_err = 0; b_err = 0; done_cnt = 0; load_cnt = 0;
      t_last = -1; t_to = -1; drain_cd = 0;
    end
    if (done) done_cnt++;
    if (b_addr_prev[5:0] == 6'd62 && b_addr[5:0] == 6'd63) load_cnt++;
    b_addr_prev = b_addr;
    if (timeout && t_to < 0) t_to = cyc;
    if (drain_cd > 0) begin
      drain_cd--;
      if (drain_cd == 0) stripe_end = 1'b1;
    end
    if (pe_start) begin
      k   = int'(b_addr[9:6]);
      row = int'(a_addr_prev);
      if (nrows[k] == 0) begin
        first_row[k] = row;
        for (int p = 0; p < 64; p++) bexp[2*p +: 2] = b_mem[64*k + p];
        if (pe_b !== bexp) b_err++;
      end else if (row != last_row[k] + 1) seq_err++;
      last_row[k] = row;
      nrows[k]++;
      if (pe_a !== a_mem[row]) a_err++;
      if (end_mode == 1 && k == 0 && row == 500) stripe_end = 1'b1;
      else if (row == 1023) begin
        if (end_mode != 2) drain_cd = 3;
        if (k == 0 && t_last < 0) t_last = cyc;
      end
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stripe-level reference: rows streamed per stripe and the best result
  int e_first [16];
  int e_last [16];
  int e_n [16];
  int eb_score, eb_row, eb_stripe;

  task automatic model(input int sp, input int mode);
    int sr, nxt;
    sr = 0; eb_score = 0; eb_row = 0; eb_stripe = 0;
    for (int k = 0; k < 16; k++) begin
      if (sr >= 1024) begin
        e_first[k] = -1; e_last[k] = -1; e_n[k] = 0;
      end else begin
        e_first[k] = sr;
        e_last[k]  = (mode == 1 && k == 0) ? 500 : 1023;
        e_n[k]     = e_last[k] - sr + 1;
        if (int'(sc_tab[k]) > eb_score) begin
          eb_score = int'(sc_tab[k]); eb_row = sr + int'(ep_tab[k]); eb_stripe = k;
        end
      end
      nxt = (mode == 2) ? 0 : sp;
      sr  = (sr + nxt > 1024) ? 1024 : sr + nxt;
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = 2'($urandom);
      b_mem[i] = 2'($urandom);
    end
  endtask

  task automatic pulse_go();
    run_id++;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic run(input string tag, input int sp, input int mode);
    bit got;
    logic [127:0] bfin;
    fill_mem();
    start_pos = 10'(sp);
    end_mode  = mode;
    model(sp, mode);
    pulse_go();
    chk({tag, " busy_after_go"}, 128'(busy), 128'(1));
    chk({tag, " timeout_cleared"}, 128'(timeout), 128'(0));
    got = 1'b0;
    for (int c = 0; c < 40000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({tag, " done_seen"}, 128'(got), 128'(1));
    repeat (3) @(negedge clk);
    chk({tag, " done_pulses"}, 128'(done_cnt), 128'(1));
    chk({tag, " b_loads"}, 128'(load_cnt), 128'(16));
    chk({tag, " busy_end"}, 128'(busy), 128'(0));
    chk({tag, " a_data_err"}, 128'(a_err), 128'(0));
    chk({tag, " row_seq_err"}, 128'(seq_err), 128'(0));
    chk({tag, " b_vec_err"}, 128'(b_err), 128'(0));
    chk({tag, " timeout_end"}, 128'(timeout), 128'(mode == 2));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s first_row[%0d]", tag, k), 128'(first_row[k]), 128'(e_first[k]));
      chk($sformatf("%s last_row[%0d]", tag, k), 128'(last_row[k]), 128'(e_last[k]));
      chk($sformatf("%s nrows[%0d]", tag, k), 128'(nrows[k]), 128'(e_n[k]));
    end
    chk({tag, " best_score"}, 128'(best_score), 128'(eb_score));
    chk({tag, " best_row"}, 128'(best_row), 128'(eb_row));
    chk({tag, " best_stripe"}, 128'(best_stripe), 128'(eb_stripe));
    for (int p = 0; p < 64; p++) bfin[2*p +: 2] = b_mem[960 + p];
    chk({tag, " final_pe_b"}, pe_b, bfin);
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 16; i++) begin sc_tab[i] = '0; ep_tab[i] = '0; end
    fill_mem();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst done", 128'(done), 128'(0));
    chk("rst timeout", 128'(timeout), 128'(0));
    chk("rst a_addr", 128'(a_addr), 128'(0));
    chk("rst b_addr", 128'(b_addr), 128'(0));
    chk("rst pe_start", 128'(pe_start), 128'(0));
    chk("rst pe_a", 128'(pe_a), 128'(0));
    chk("rst pe_b", pe_b, 128'(0));
    chk("rst best_score", 128'(best_score), 128'(0));
    chk("rst best_row", 128'(best_row), 128'(0));
    chk("rst best_stripe", 128'(best_stripe), 128'(0));
    rst_n = 1'b1;

    // reset while streaming row 300 of stripe 0
    start_pos = 10'd40;
    end_mode  = 0;
    pulse_go();
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (pe_start && a_addr_prev == 10'd300) got = 1'b1;
    end
    chk("midrst reached_row300", 128'(got), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst pe_start", 128'(pe_start), 128'(0));
    chk("midrst pe_a", 128'(pe_a), 128'(0));
    chk("midrst pe_b", pe_b, 128'(0));
    chk("midrst busy", 128'(busy), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // scores 100,250,250,90 at start rows 0,40,80,120 with end offset 10
    sc_tab[0] = 14'd100; sc_tab[1] = 14'd250; sc_tab[2] = 14'd250; sc_tab[3] = 14'd90;
    for (int i = 4; i < 16; i++) sc_tab[i] = 14'($urandom_range(0, 249));
    for (int i = 0; i < 16; i++) ep_tab[i] = 10'd10;
    run("sp40", 40, 0);
    chk("sp40 best_score_const", 128'(best_score), 128'(250));
    chk("sp40 best_row_const", 128'(best_row), 128'(50));
    chk("sp40 best_stripe_const", 128'(best_stripe), 128'(1));

    for (int i = 0; i < 16; i++) begin
      sc_tab[i] = 14'($urandom);
      ep_tab[i] = 10'($urandom);
    end
    run("early", int'($urandom_range(60, 90)), 1);

    for (int i = 0; i < 16; i++) begin
      sc_tab[i] = 14'($urandom);
      ep_tab[i] = 10'($urandom);
    end
    run("sat", int'($urandom_range(150, 300)), 0);

    for (int i = 0; i < 16; i++) begin
      sc_tab[i] = '0;
      ep_tab[i] = 10'($urandom);
    end
    run("tmo", 40, 2);
    chk("tmo drain_latency", 128'(t_to - t_last), 128'(129));

    for (int i = 0; i < 16; i++) begin
      sc_tab[i] = 14'($urandom);
      ep_tab[i] = 10'($urandom);
    end
    run("after_tmo", 300, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
